// File: rtl/fullchip_seq.sv
// fullchip_seq
//   Instruction sequencer for the two-core fullchip array. One host start
//   command becomes the complete inst stream: K load, Q load, kernel preload,
//   execute, drain, optional normalise and psum readout.
//
//   Build option: define FULLCHIP_SEQ_NORM_EN to insert the NRM phase after DRN.
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous active-low reset
//     start      one-cycle start pulse, sampled only in IDLE
//     num_k      K rows to load (1..2**aw), latched at start
//     num_q      Q rows to load/execute (1..2**aw), latched at start
//     in_valid   host presents a mem_in word
//     in_ready   sequencer consumes the mem_in word this cycle
//     inst       instruction bus to both cores
//     out_ready  host accepts a psum row
//     out_valid  fullchip out holds the row read by the previous pmem_rd
//     busy       sequence in progress
//     done       one-cycle completion pulse
//
//   All outputs are registered, so each state's bus value appears one cycle
//   after the state register holds it.
//
//   state | meaning
//   IDLE  | wait for start with legal counts
//   LDK   | kmem_wr per accepted mem_in word, addr 0..num_k-1
//   LDQ   | qmem_wr per accepted mem_in word, addr 0..num_q-1
//   PRE   | kmem_rd + load, addr 0..num_k-1
//   GAP   | pr idle cycles for kernel settle
//   EXE   | qmem_rd + execute + pmem_wr, addr 0..num_q-1
//   DRN   | col+pr idle cycles for psum pipeline flush
//   NRM   | norm + pmem_rd + pmem_wr, addr 0..num_q-1 (optional)
//   RD    | pmem_rd when out_ready, addr 0..num_q-1
//   DONE  | completion pulse, back to IDLE

module fullchip_seq #(
    parameter int col    = 8,
    parameter int pr     = 8,
    parameter int aw     = 4,
    parameter int inst_w = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [aw:0]       num_k,
    input  logic [aw:0]       num_q,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [inst_w-1:0] inst,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int          TW      = $clog2(col + pr + 1);
    localparam logic [aw:0] MAX_CNT = (aw+1)'(2**aw);
    localparam logic [aw:0] ONE     = (aw+1)'(1);

    localparam logic [9:0] S_KWR  = 10'h001;
    localparam logic [9:0] S_QWR  = 10'h002;
    localparam logic [9:0] S_KRD  = 10'h004;
    localparam logic [9:0] S_QRD  = 10'h008;
    localparam logic [9:0] S_PWR  = 10'h010;
    localparam logic [9:0] S_PRD  = 10'h020;
    localparam logic [9:0] S_LOAD = 10'h040;
    localparam logic [9:0] S_EXE  = 10'h080;
    localparam logic [9:0] S_NORM = 10'h100;

    typedef enum logic [3:0] {
        IDLE, LDK, LDQ, PRE, GAP, EXE, DRN, NRM, RD, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [aw:0]         nk_q, nk_d, nq_q, nq_d;
    // One address pointer serves as k_ptr, q_ptr and r_ptr; each phase restarts it at 0.
    logic [aw:0]         ptr_q, ptr_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic                rd_q, rd_d;
    logic [inst_w-1:0]   inst_q, inst_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [9:0]          strb;
    logic                last_k, last_q, counts_ok;

    assign last_k    = (ptr_q == nk_q - ONE);
    assign last_q    = (ptr_q == nq_q - ONE);
    assign counts_ok = (num_k != '0) && (num_k <= MAX_CNT) &&
                       (num_q != '0) && (num_q <= MAX_CNT);

    always_comb begin
        state_d = state_q;
        nk_d    = nk_q;
        nq_d    = nq_q;
        ptr_d   = ptr_q;
        tmr_d   = tmr_q;
        rd_d    = 1'b0;
        done_d  = 1'b0;
        strb    = '0;
        case (state_q)
            IDLE: begin
                if (start && counts_ok) begin
                    nk_d    = num_k;
                    nq_d    = num_q;
                    ptr_d   = '0;
                    state_d = LDK;
                end
            end
            LDK: begin
                if (in_valid) begin
                    strb  = S_KWR;
                    ptr_d = ptr_q + ONE;
                    if (last_k) begin
                        ptr_d   = '0;
                        state_d = LDQ;
                    end
                end
            end
            LDQ: begin
                if (in_valid) begin
                    strb  = S_QWR;
                    ptr_d = ptr_q + ONE;
                    if (last_q) begin
                        ptr_d   = '0;
                        state_d = PRE;
                    end
                end
            end
            PRE: begin
                strb  = S_KRD | S_LOAD;
                ptr_d = ptr_q + ONE;
                if (last_k) begin
                    ptr_d   = '0;
                    tmr_d   = TW'(pr - 1);
                    state_d = GAP;
                end
            end
            GAP: begin
                tmr_d = tmr_q - TW'(1);
                if (tmr_q == '0) begin
                    tmr_d   = '0;
                    state_d = EXE;
                end
            end
            EXE: begin
                strb  = S_QRD | S_EXE | S_PWR;
                ptr_d = ptr_q + ONE;
                if (last_q) begin
                    ptr_d   = '0;
                    tmr_d   = TW'(col + pr - 1);
                    state_d = DRN;
                end
            end
            DRN: begin
                tmr_d = tmr_q - TW'(1);
                if (tmr_q == '0) begin
                    tmr_d = '0;
`ifdef FULLCHIP_SEQ_NORM_EN
                    state_d = NRM;
`else
                    state_d = RD;
`endif
                end
            end
`ifdef FULLCHIP_SEQ_NORM_EN
            NRM: begin
                strb  = S_NORM | S_PRD | S_PWR;
                ptr_d = ptr_q + ONE;
                if (last_q) begin
                    ptr_d   = '0;
                    state_d = RD;
                end
            end
`endif
            RD: begin
                if (out_ready) begin
                    strb  = S_PRD;
                    rd_d  = 1'b1;
                    ptr_d = ptr_q + ONE;
                    if (last_q) begin
                        ptr_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A stalled or idle cycle must put an all-zero word on the bus, address included.
        inst_d = '0;
        if (strb != '0) begin
            inst_d[9:0]     = strb;
            inst_d[14 +: aw] = ptr_q[aw-1:0];
        end

        in_ready_d  = (state_d == LDK) || (state_d == LDQ);
        // busy covers the done pulse and drops the cycle after it.
        busy_d      = (state_d != IDLE) || (state_q == DONE);
        out_valid_d = rd_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            nk_q        <= '0;
            nq_q        <= '0;
            ptr_q       <= '0;
            tmr_q       <= '0;
            rd_q        <= 1'b0;
            inst_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nk_q        <= nk_d;
            nq_q        <= nq_d;
            ptr_q       <= ptr_d;
            tmr_q       <= tmr_d;
            rd_q        <= rd_d;
            inst_q      <= inst_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign inst      = inst_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fullchip_seq.sv
// Testbench for fullchip_seq: directed runs with an expected-sample queue.
// Each planned state cycle records its input drive and the bus word it must
// produce; the resulting expected output samples are queued and popped one
// per clock as the DUT runs.
module tb_fullchip_seq;

    localparam int COL = 8;
    localparam int PR  = 8;
    localparam int AW  = 4;

    localparam logic [9:0] KWR  = 10'h001;
    localparam logic [9:0] QWR  = 10'h002;
    localparam logic [9:0] KRD  = 10'h004;
    localparam logic [9:0] QRD  = 10'h008;
    localparam logic [9:0] PWR  = 10'h010;
    localparam logic [9:0] PRD  = 10'h020;
    localparam logic [9:0] LOAD = 10'h040;
    localparam logic [9:0] EXE  = 10'h080;
    localparam logic [9:0] NORM = 10'h100;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, out_ready;
    logic [AW:0]   num_k, num_q;
    logic          in_ready, out_valid, busy, done;
    logic [19:0]   inst;

    always #5 clk = ~clk;

    fullchip_seq #(.col(COL), .pr(PR), .aw(AW), .inst_w(20)) dut (
        .clk(clk), .reset(reset), .start(start), .num_k(num_k), .num_q(num_q),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .out_ready(out_ready), .out_valid(out_valid), .busy(busy), .done(done)
    );

    typedef struct {
        logic [19:0] inst;
        logic        ir;
        logic        ov;
        logic        dn;
        logic        bz;
    } exp_t;

    exp_t        sbq[$];
    logic [19:0] c_inst[$];
    bit          c_iv[$], c_or[$], c_ld[$], c_rd[$], c_dn[$];

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [19:0] mk(input logic [9:0] s, input int a);
        return 20'(s) | (20'(a) << 14);
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [19:0] o, input bit v, input bit r, input bit l,
                       input bit rd, input bit dn);
        c_inst.push_back(o); c_iv.push_back(v); c_or.push_back(r);
        c_ld.push_back(l); c_rd.push_back(rd); c_dn.push_back(dn);
    endtask

    // Plan one complete sequence and queue the expected output samples.
    task automatic plan(input int nk, input int nq, input bit tog, input int stall_at);
        int c = 0;
        int k = 0;
        int s = 0;
        int n;
        exp_t e;
        bit v;
        c_inst.delete(); c_iv.delete(); c_or.delete();
        c_ld.delete(); c_rd.delete(); c_dn.delete();
        while (k < nk) begin
            v = tog ? (c % 2 == 0) : 1'b1;
            cyc(v ? mk(KWR, k) : 20'h0, v, 1, 1, 0, 0);
            if (v) k++;
            c++;
        end
        k = 0;
        while (k < nq) begin
            v = tog ? (c % 2 == 0) : 1'b1;
            cyc(v ? mk(QWR, k) : 20'h0, v, 1, 1, 0, 0);
            if (v) k++;
            c++;
        end
        for (int i = 0; i < nk; i++) cyc(mk(KRD | LOAD, i), 0, 1, 0, 0, 0);
        for (int i = 0; i < PR; i++) cyc(20'h0, 0, 1, 0, 0, 0);
        for (int i = 0; i < nq; i++) cyc(mk(QRD | EXE | PWR, i), 0, 1, 0, 0, 0);
        for (int i = 0; i < COL + PR; i++) cyc(20'h0, 0, 1, 0, 0, 0);
`ifdef FULLCHIP_SEQ_NORM_EN
        for (int i = 0; i < nq; i++) cyc(mk(NORM | PRD | PWR, i), 0, 1, 0, 0, 0);
`endif
        k = 0;
        while (k < nq) begin
            if (k == stall_at && s < 5) begin
                cyc(20'h0, 0, 0, 0, 0, 0);
                s++;
            end else begin
                cyc(mk(PRD, k), 0, 1, 0, 1, 0);
                k++;
            end
        end
        cyc(20'h0, 0, 1, 0, 0, 1);   // DONE
        cyc(20'h0, 0, 1, 0, 0, 0);   // back in IDLE
        n = c_inst.size();
        for (int j = 0; j <= n; j++) begin
            e.inst = (j == 0) ? 20'h0 : c_inst[j-1];
            e.ir   = (j < n) ? c_ld[j] : 1'b0;
            e.ov   = (j >= 2) ? c_rd[j-2] : 1'b0;
            e.dn   = (j >= 1) ? c_dn[j-1] : 1'b0;
            e.bz   = (j < n);
            sbq.push_back(e);
        end
    endtask

    // Issue start and compare one sample per clock; optionally pulse a second
    // start mid-run or stop early at sample abort_at.
    task automatic run(input string name, input int nk, input int nq,
                       input int abort_at, input int busy_start_at);
        int j = 0;
        exp_t e;
        @(negedge clk);
        num_k = (AW+1)'(nk);
        num_q = (AW+1)'(nq);
        start = 1'b1;
        while (sbq.size() > 0) begin
            @(negedge clk);
            e = sbq.pop_front();
            chk($sformatf("%s inst[%0d]", name, j), inst, e.inst);
            chk($sformatf("%s in_ready[%0d]", name, j), 20'(in_ready), 20'(e.ir));
            chk($sformatf("%s out_valid[%0d]", name, j), 20'(out_valid), 20'(e.ov));
            chk($sformatf("%s done[%0d]", name, j), 20'(done), 20'(e.dn));
            chk($sformatf("%s busy[%0d]", name, j), 20'(busy), 20'(e.bz));
            if (j == abort_at) begin
                sbq.delete();
                start = 1'b0;
                return;
            end
            start = (j == busy_start_at);
            if (j == busy_start_at) begin
                num_k = (AW+1)'(1);
                num_q = (AW+1)'(1);
            end
            in_valid  = (j < c_iv.size()) ? c_iv[j] : 1'b0;
            out_ready = (j < c_or.size()) ? c_or[j] : 1'b0;
            j++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic bad_start(input string name, input int nk, input int nq);
        @(negedge clk);
        num_k = (AW+1)'(nk);
        num_q = (AW+1)'(nq);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s busy[%0d]", name, i), 20'(busy), 20'h0);
            chk($sformatf("%s inst[%0d]", name, i), inst, 20'h0);
            chk($sformatf("%s in_ready[%0d]", name, i), 20'(in_ready), 20'h0);
            @(negedge clk);
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        num_k     = '0;
        num_q     = '0;
        repeat (2) @(negedge clk);
        chk("rst inst", inst, 20'h0);
        chk("rst busy", 20'(busy), 20'h0);
        chk("rst done", 20'(done), 20'h0);
        chk("rst in_ready", 20'(in_ready), 20'h0);
        chk("rst out_valid", 20'(out_valid), 20'h0);
        reset = 1'b1;

        // Reset asserted during EXE (sample 22 shows the second execute word).
        plan(4, 4, 0, -1);
        run("abort", 4, 4, 22, -1);
        reset = 1'b0;
        #1;
        chk("midrst inst", inst, 20'h0);
        chk("midrst busy", 20'(busy), 20'h0);
        chk("midrst in_ready", 20'(in_ready), 20'h0);
        chk("midrst out_valid", 20'(out_valid), 20'h0);
        chk("midrst done", 20'(done), 20'h0);
        @(negedge clk);
        reset = 1'b1;

        // Basic run, then toggling in_valid with a start pulse while busy.
        plan(2, 3, 0, -1);
        run("basic", 2, 3, -1, -1);
        plan(2, 3, 1, -1);
        run("toggle", 2, 3, -1, 5);

        // Full-depth run: addresses 0..15 in every phase.
        plan(16, 16, 0, -1);
        run("full", 16, 16, -1, -1);

        // Illegal counts are ignored.
        bad_start("q0", 4, 0);
        bad_start("k17", 17, 4);
        bad_start("k0", 0, 2);

        // Readout stalled for 5 cycles after the first row.
        plan(2, 3, 0, 1);
        run("stall", 2, 3, -1, -1);

        // A legal start still works after the rejected ones.
        plan(1, 1, 0, -1);
        run("min", 1, 1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
